// File: rtl/realtank_ahb_reg_slave.sv
// AHB-Lite register responder: NUM_REGS x 32-bit control registers with
// programmable wait states and two-cycle ERROR for unmapped/illegal accesses.
module realtank_ahb_reg_slave #(
  parameter int ADDR_W      = 12,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     HSEL,
  input  logic [ADDR_W-1:0]        HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic [31:0]              HWDATA,
  input  logic                     HREADY,
  output logic                     HREADYOUT,
  output logic [1:0]               HRESP,
  output logic [31:0]              HRDATA,
  output logic [NUM_REGS*32-1:0]   reg_q
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_ERR1  = 2'd2;
  localparam logic [1:0] ST_ERR2  = 2'd3;

  localparam logic [3:0]        CNT_LOAD   = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
  localparam logic [ADDR_W-2:0] NUM_REGS_W = (ADDR_W-1)'(NUM_REGS);

  function automatic logic f_legal(input logic [ADDR_W-1:0] addr, input logic [2:0] size);
    logic ok;
    ok = ({1'b0, addr[ADDR_W-1:2]} < NUM_REGS_W);
    case (size)
      3'b000:  f_legal = ok;
      3'b001:  f_legal = ok & ~addr[0];
      3'b010:  f_legal = ok & (addr[1:0] == 2'b00);
      default: f_legal = 1'b0;
    endcase
  endfunction

  // Little-endian byte-lane enables for a legal access.
  function automatic logic [3:0] f_lanes(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      3'b000:  f_lanes = 4'b0001 << lo;
      3'b001:  f_lanes = lo[1] ? 4'b1100 : 4'b0011;
      default: f_lanes = 4'b1111;
    endcase
  endfunction

  logic [1:0]             r_state;
  logic [3:0]             r_cnt;
  logic                   r_valid;
  logic                   r_write;
  logic [2:0]             r_size;
  logic [1:0]             r_lo;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_hreadyout;
  logic [1:0]             r_hresp;
  logic [NUM_REGS*32-1:0] r_regs;

  logic       w_accept;
  logic       w_legal;
  logic [1:0] w_state_nxt;
  logic       w_commit;
  logic       w_rd_en;
  logic [3:0] w_be;
  logic       w_unused;

  assign w_unused  = HTRANS[0];
  assign w_accept  = r_hreadyout & HSEL & HREADY & HTRANS[1];
  assign w_legal   = f_legal(HADDR, HSIZE);
  assign w_commit  = (r_state == ST_READY) & r_valid & r_write;
  assign w_rd_en   = (r_state == ST_READY) & r_valid & ~r_write;
  assign w_be      = f_lanes(r_size, r_lo);
  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;
  assign reg_q     = r_regs;

  // Next-state decode for the data-phase FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_READY, ST_ERR2: begin
        if (w_accept) begin
          if (!w_legal) begin
            w_state_nxt = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_state_nxt = ST_WAIT;
          end else begin
            w_state_nxt = ST_READY;
          end
        end else begin
          w_state_nxt = ST_READY;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_READY;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: w_state_nxt = ST_READY;
    endcase
  end

  // State, wait counter and the registered response outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_READY;
      r_cnt       <= 4'd0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 2'b00;
    end else begin
      r_state     <= w_state_nxt;
      r_hreadyout <= (w_state_nxt == ST_READY) | (w_state_nxt == ST_ERR2);
      r_hresp     <= (w_state_nxt == ST_ERR1) | (w_state_nxt == ST_ERR2) ? 2'b01 : 2'b00;
      if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end else if (w_accept & w_legal) begin
        r_cnt <= CNT_LOAD;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Address-phase capture; held while our own data phase is stalled.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_valid <= 1'b0;
      r_write <= 1'b0;
      r_size  <= 3'b000;
      r_lo    <= 2'b00;
      r_idx   <= {IDX_W{1'b0}};
    end else if (r_hreadyout) begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_write <= HWRITE;
        r_size  <= HSIZE;
        r_lo    <= HADDR[1:0];
        r_idx   <= HADDR[IDX_W+1:2];
      end
    end
  end

  // Register file: byte-lane write commit at the end of the completing cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_regs <= {(NUM_REGS*32){1'b0}};
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        for (int b = 0; b < 4; b++) begin
          if (w_commit && (r_idx == IDX_W'(k)) && w_be[b]) begin
            r_regs[32*k+8*b +: 8] <= HWDATA[8*b +: 8];
          end
        end
      end
    end
  end

  // Read data is driven only in a read's completing cycle.
  always_comb begin
    if (w_rd_en) begin
      HRDATA = r_regs[{r_idx, 5'd0} +: 32];
    end else begin
      HRDATA = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_realtank_ahb_reg_slave.sv
// Bench for realtank_ahb_reg_slave: WAIT_STATES=0 and WAIT_STATES=3 instances
// driven by a pipelined AHB master against a byte-lane register model.
module tb_realtank_ahb_reg_slave;

  localparam int NR = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rstn, hsel, hwrite, hreadyout, hready_ovr, bus_hready;
  logic [11:0]     haddr [2];
  logic [1:0]      htrans[2];
  logic [2:0]      hsize [2];
  logic [31:0]     hwdata[2];
  logic [31:0]     hrdata[2];
  logic [1:0]      hresp [2];
  logic [NR*32-1:0] regq [2];

  assign bus_hready = hreadyout & ~hready_ovr;

  realtank_ahb_reg_slave #(.ADDR_W(12), .NUM_REGS(NR), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESETn(rstn[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]), .HREADY(bus_hready[0]),
    .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]), .reg_q(regq[0]));

  realtank_ahb_reg_slave #(.ADDR_W(12), .NUM_REGS(NR), .WAIT_STATES(3)) u_dut1 (
    .HCLK(clk), .HRESETn(rstn[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]), .HREADY(bus_hready[1]),
    .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]), .reg_q(regq[1]));

  typedef struct {
    bit        sel;
    bit [1:0]  trans;
    bit        wr;
    bit [11:0] addr;
    bit [2:0]  size;
    bit [31:0] wdata;
  } tx_t;

  tx_t       txq[$];
  bit [31:0] mdl[2][NR];
  bit        ovr_en;
  int        n_checks;
  int        n_errors;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic bit is_legal(input tx_t t);
    if (int'(t.addr) / 4 >= NR) return 1'b0;
    if (t.size > 3'd2) return 1'b0;
    return (int'(t.addr) % (1 << t.size)) == 0;
  endfunction

  task automatic apply_write(input int d, input tx_t t);
    int lo;
    int nb;
    lo = int'(t.addr) % 4;
    nb = 1 << t.size;
    for (int b = 0; b < 4; b++)
      if (b >= lo && b < lo + nb)
        mdl[d][int'(t.addr) / 4][8*b +: 8] = t.wdata[8*b +: 8];
  endtask

  task automatic push(input bit sel, input bit [1:0] trans, input bit wr,
                      input bit [11:0] addr, input bit [2:0] size, input bit [31:0] wdata);
    tx_t t;
    t.sel = sel; t.trans = trans; t.wr = wr; t.addr = addr; t.size = size; t.wdata = wdata;
    txq.push_back(t);
  endtask

  task automatic drive_idle(input int d);
    hsel[d] = 1'b0; htrans[d] = 2'b00; hwrite[d] = 1'b0;
    haddr[d] = 12'h000; hsize[d] = 3'b000; hready_ovr[d] = 1'b0;
  endtask

  task automatic check_regq(input int d);
    for (int k = 0; k < NR; k++)
      check_eq($sformatf("regq%0d_%0d", d, k), regq[d][32*k +: 32], mdl[d][k]);
  endtask

  // Pipelined master: called at posedge+1, returns at posedge+1.
  task automatic run_seq(input int d);
    int  ap;
    int  cyc;
    int  waits;
    bit  dp_act;
    bit  lg;
    tx_t dp;
    ap = 0; cyc = 0; waits = 0; dp_act = 1'b0; lg = 1'b0;
    while ((ap < txq.size() || dp_act) && cyc < 2000) begin
      hready_ovr[d] = ovr_en && !dp_act && ($urandom_range(0, 7) == 0);
      if (ap < txq.size()) begin
        hsel[d] = txq[ap].sel; htrans[d] = txq[ap].trans; hwrite[d] = txq[ap].wr;
        haddr[d] = txq[ap].addr; hsize[d] = txq[ap].size;
      end else begin
        hsel[d] = 1'b0; htrans[d] = 2'b00; hwrite[d] = 1'b0;
        haddr[d] = 12'($urandom); hsize[d] = 3'b010;
      end
      hwdata[d] = dp_act ? dp.wdata : $urandom;
      @(negedge clk);
      if (dp_act) begin
        if (hreadyout[d]) begin
          check_eq("resp", hresp[d], lg ? 2'b00 : 2'b01);
          check_eq("waits", waits, lg ? ws_of(d) : 1);
          check_eq("rdata", hrdata[d], (lg && !dp.wr) ? mdl[d][int'(dp.addr) / 4] : 32'h0);
          if (lg && dp.wr) apply_write(d, dp);
          dp_act = 1'b0;
        end else begin
          waits++;
          check_eq("wait_resp", {hresp[d], hrdata[d]}, {(lg ? 2'b00 : 2'b01), 32'h0});
        end
      end else begin
        check_eq("idle", {hreadyout[d], hresp[d], hrdata[d]}, {1'b1, 2'b00, 32'h0});
      end
      if (bus_hready[d] && ap < txq.size()) begin
        if (txq[ap].sel && txq[ap].trans[1]) begin
          dp = txq[ap]; dp_act = 1'b1; waits = 0; lg = is_legal(dp);
        end
        ap++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 2000) check_eq("timeout", 1, 0);
    txq.delete();
    drive_idle(d);
  endtask

  task automatic gen_random(input int n);
    bit [2:0]  sz;
    bit [11:0] a;
    int        r;
    for (int i = 0; i < n; i++) begin
      r  = $urandom_range(0, 9);
      sz = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      a  = 12'($urandom_range(0, 40));
      if ($urandom_range(0, 9) < 7 && sz <= 3'd2) a = a & ~12'((1 << sz) - 1);
      push($urandom_range(0, 9) != 0, (r < 6) ? 2'b10 : (r < 8) ? 2'b11 : (r < 9) ? 2'b00 : 2'b01,
           1'($urandom), a, sz, $urandom);
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; ovr_en = 1'b0;
    rstn = 2'b00;
    for (int d = 0; d < 2; d++) begin
      drive_idle(d);
      hwdata[d] = 32'h0;
      for (int k = 0; k < NR; k++) mdl[d][k] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_out", {hreadyout[d], hresp[d], hrdata[d]}, {1'b1, 2'b00, 32'h0});
      check_regq(d);
    end
    rstn = 2'b11;
    @(posedge clk); #1;

    // Word write then read back, zero waits.
    push(1, 2'b10, 1, 12'h004, 3'b010, 32'hDEADBEEF);
    push(1, 2'b10, 0, 12'h004, 3'b010, 32'h0);
    run_seq(0);
    check_eq("deadbeef", regq[0][63:32], 32'hDEADBEEF);

    // Byte and halfword lane writes.
    push(1, 2'b10, 1, 12'h004, 3'b010, 32'h11223344);
    push(1, 2'b11, 1, 12'h006, 3'b000, 32'h00AA0000);
    run_seq(0);
    check_eq("byte_lane", regq[0][63:32], 32'h11AA3344);
    push(1, 2'b10, 1, 12'h004, 3'b001, 32'h00005566);
    push(1, 2'b10, 0, 12'h004, 3'b010, 32'h0);
    run_seq(0);
    check_eq("half_lane", regq[0][63:32], 32'h11AA5566);

    // Unmapped, misaligned, oversize, BUSY: errors or ignored, no register change.
    push(1, 2'b10, 0, 12'h020, 3'b010, 32'h0);
    push(1, 2'b10, 1, 12'h002, 3'b010, 32'hFFFFFFFF);
    push(1, 2'b10, 1, 12'h000, 3'b011, 32'hFFFFFFFF);
    push(1, 2'b01, 1, 12'h00C, 3'b010, 32'hFFFFFFFF);
    run_seq(0);
    check_regq(0);

    // HREADY low (another slave's data phase) masks a NONSEQ write.
    hready_ovr[0] = 1'b1;
    hsel[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b1; haddr[0] = 12'h00C; hsize[0] = 3'b010;
    @(negedge clk);
    check_eq("hready0_a", {hreadyout[0], hresp[0], hrdata[0]}, {1'b1, 2'b00, 32'h0});
    @(posedge clk); #1;
    drive_idle(0);
    hwdata[0] = 32'hFFFFFFFF;
    @(negedge clk);
    check_eq("hready0_b", {hreadyout[0], hresp[0], hrdata[0]}, {1'b1, 2'b00, 32'h0});
    @(posedge clk); #1;
    check_regq(0);

    // WAIT_STATES=3: read then back-to-back write of reg0.
    push(1, 2'b10, 1, 12'h000, 3'b010, 32'h0BADF00D);
    run_seq(1);
    push(1, 2'b10, 0, 12'h000, 3'b010, 32'h0);
    push(1, 2'b11, 1, 12'h000, 3'b010, 32'h12345678);
    run_seq(1);
    check_eq("ws3_b2b", regq[1][31:0], 32'h12345678);

    // Reset in the WAIT of a pending write.
    hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1; haddr[1] = 12'h008; hsize[1] = 3'b010;
    @(posedge clk); #1;
    drive_idle(1);
    hwdata[1] = 32'hCAFEF00D;
    @(negedge clk);
    check_eq("pre_rst_wait", hreadyout[1], 1'b0);
    #2 rstn[1] = 1'b0;
    #1 check_eq("mid_rst", {hreadyout[1], hresp[1], hrdata[1]}, {1'b1, 2'b00, 32'h0});
    @(negedge clk);
    rstn[1] = 1'b1;
    for (int k = 0; k < NR; k++) mdl[1][k] = 32'h0;
    @(posedge clk); #1;
    check_regq(1);
    push(1, 2'b10, 0, 12'h008, 3'b010, 32'h0);
    run_seq(1);

    // Randomized pipelined traffic on both instances.
    ovr_en = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int blk = 0; blk < 4; blk++) begin
        gen_random(40);
        run_seq(d);
        check_regq(d);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
